// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the program-counter stage: FSM states, default widths, branch-target table.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pc_branch_unit_pkg;

  localparam int PCW_DEF  = 10;
  localparam int LUTW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  // Absolute branch targets: entry i is i*8+16, except the last entry which
  // points at the top of instruction memory so wrap-around can be exercised.
  localparam logic [PCW_DEF-1:0] PC_LUT [2**LUTW_DEF] = '{
    10'd16,  10'd24,  10'd32,  10'd40,  10'd48,  10'd56,  10'd64,  10'd72,
    10'd80,  10'd88,  10'd96,  10'd104, 10'd112, 10'd120, 10'd128, 10'd136,
    10'd144, 10'd152, 10'd160, 10'd168, 10'd176, 10'd184, 10'd192, 10'd200,
    10'd208, 10'd216, 10'd224, 10'd232, 10'd240, 10'd248, 10'd256, 10'd1023
  };

endpackage

// File: rtl/pc_lut.sv
// Branch-target lookup: maps a target index to an absolute program counter value.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the index.
module pc_lut
  import pc_branch_unit_pkg::*;
#(
  parameter int PCW  = PCW_DEF,
  parameter int LUTW = LUTW_DEF
) (
  input  logic [LUTW-1:0] target_idx,
  output logic [PCW-1:0]  target_pc
);

  // Straight table read; the table itself lives in the package.
  assign target_pc = PCW'(PC_LUT[target_idx]);

endmodule

// File: rtl/pc_branch_unit.sv
// Program-counter stage: fetch sequencing, zero-flag register, jump/branch resolution via target LUT.
// Latency: taken branch lands on ProgCtr one cycle later (no delay slot); flag updates at the edge.
// Backpressure: Stall freezes PC, state and flag for the cycle. Macro FLAG_BYPASS_EN forwards Zero_in to branches.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int PCW  = PCW_DEF,
  parameter int LUTW = LUTW_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Halt,
  input  logic            Jump,
  input  logic            BranchZ,
  input  logic            BranchNZ,
  input  logic [LUTW-1:0] TargetIdx,
  input  logic            FlagWrite,
  input  logic            Zero_in,
  output logic [PCW-1:0]  ProgCtr,
  output logic            ZeroFlag,
  output logic            Running,
  output logic            Done
);

  pc_state_t       state;
  logic [PCW-1:0]  target_pc;
  logic            flag_eff;
  logic            taken;

  pc_lut #(
    .PCW  (PCW),
    .LUTW (LUTW)
  ) u_lut (
    .target_idx (TargetIdx),
    .target_pc  (target_pc)
  );

`ifdef FLAG_BYPASS_EN
  // Forward the flag being written this cycle so a branch can consume it immediately.
  assign flag_eff = FlagWrite ? Zero_in : ZeroFlag;
`else
  // Branches see only the registered flag; a dependent branch needs one instruction of spacing.
  assign flag_eff = ZeroFlag;
`endif

  // Multiple branch requests simply OR together.
  assign taken = Jump | (BranchZ & flag_eff) | (BranchNZ & ~flag_eff);

  // Sequencer FSM with PC, flag and status outputs all registered together.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      ProgCtr  <= '0;
      ZeroFlag <= 1'b0;
      Running  <= 1'b0;
      Done     <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (Start) begin
            state   <= RUN;
            ProgCtr <= '0;
            Running <= 1'b1;
            Done    <= 1'b0;
          end
        end
        RUN: begin
          if (!Stall) begin
            if (FlagWrite) begin
              ZeroFlag <= Zero_in;
            end
            if (Halt) begin
              state   <= HALTED;
              Running <= 1'b0;
              Done    <= 1'b1;
            end else if (taken) begin
              ProgCtr <= target_pc;
            end else begin
              ProgCtr <= ProgCtr + PCW'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios with literal expectations, then randomized traffic.
// Latency: compares DUT outputs against a behavioural model every falling edge.
// Backpressure: Stall, Halt and async reset are all exercised in the random phase.
module tb_pc_branch_unit;

  logic       Clk;
  logic       Reset;
  logic       Start, Stall, Halt, Jump, BranchZ, BranchNZ, FlagWrite, Zero_in;
  logic [4:0] TargetIdx;
  logic [9:0] ProgCtr;
  logic       ZeroFlag, Running, Done;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Model state: 0 idle, 1 running, 2 halted
  int m_state;
  int m_pc;
  int m_flag;

  pc_branch_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Stall     (Stall),
    .Halt      (Halt),
    .Jump      (Jump),
    .BranchZ   (BranchZ),
    .BranchNZ  (BranchNZ),
    .TargetIdx (TargetIdx),
    .FlagWrite (FlagWrite),
    .Zero_in   (Zero_in),
    .ProgCtr   (ProgCtr),
    .ZeroFlag  (ZeroFlag),
    .Running   (Running),
    .Done      (Done)
  );

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got no end, required end");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lut(input int idx);
    return (idx == 31) ? 1023 : idx * 8 + 16;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_flag  = 0;
  endtask

  // Next-state rules applied to the inputs present at the rising edge.
  task automatic model_clk();
    int fe;
    bit tk;
    if (m_state == 1) begin
      if (!Stall) begin
`ifdef FLAG_BYPASS_EN
        fe = FlagWrite ? int'(Zero_in) : m_flag;
`else
        fe = m_flag;
`endif
        tk = Jump || (BranchZ && fe != 0) || (BranchNZ && fe == 0);
        if (FlagWrite) m_flag = int'(Zero_in);
        if (Halt)      m_state = 2;
        else if (tk)   m_pc = lut(int'(TargetIdx));
        else           m_pc = (m_pc + 1) % 1024;
      end
    end else if (Start) begin
      m_state = 1;
      m_pc    = 0;
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      check("pc",      int'(ProgCtr),  m_pc);
      check("flag",    int'(ZeroFlag), m_flag);
      check("running", int'(Running),  (m_state == 1) ? 1 : 0);
      check("done",    int'(Done),     (m_state == 2) ? 1 : 0);
    end
  end

  // Apply one cycle of inputs; returns just after the following falling edge.
  task automatic cyc(input bit st, input bit sl, input bit h, input bit j,
                     input bit bz, input bit bnz, input int idx,
                     input bit fw, input bit zi);
    Start = st; Stall = sl; Halt = h; Jump = j;
    BranchZ = bz; BranchNZ = bnz; TargetIdx = 5'(idx);
    FlagWrite = fw; Zero_in = zi;
    @(posedge Clk);
    model_clk();
    @(negedge Clk);
    #1;
  endtask

  task automatic plain();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset mid-cycle, check asynchronous effect, hold across one edge, release.
  task automatic async_reset(input bit lit);
    #2 Reset = 0;
    #1;
    if (lit) begin
      check("async_rst_pc",      int'(ProgCtr),  0);
      check("async_rst_flag",    int'(ZeroFlag), 0);
      check("async_rst_running", int'(Running),  0);
      check("async_rst_done",    int'(Done),     0);
    end
    model_reset();
    @(negedge Clk);
    #1 Reset = 1;
  endtask

  initial begin
    Reset = 0;
    Start = 0; Stall = 0; Halt = 0; Jump = 0; BranchZ = 0; BranchNZ = 0;
    TargetIdx = 0; FlagWrite = 0; Zero_in = 0;
    model_reset();
    @(negedge Clk);
    #1;
    check("reset_pc",      int'(ProgCtr),  0);
    check("reset_flag",    int'(ZeroFlag), 0);
    check("reset_running", int'(Running),  0);
    check("reset_done",    int'(Done),     0);
    Reset = 1;
    chk_en = 1;

    // Start then five plain cycles: 0,1,2,3,4,5
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("start_pc", int'(ProgCtr), 0);
    check("start_running", int'(Running), 1);
    for (int i = 1; i <= 5; i++) begin
      plain();
      check("seq_pc", int'(ProgCtr), i);
    end
    for (int i = 0; i < 4; i++) plain();
    check("pc_before_jump", int'(ProgCtr), 9);

    // Jump via LUT[3]
    cyc(0, 0, 0, 1, 0, 0, 3, 0, 0);
    check("jump_pc", int'(ProgCtr), 40);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 1, 0, 0, 7, 1, 1);
      check("stall_pc", int'(ProgCtr), 40);
      check("stall_flag", int'(ZeroFlag), 0);
    end

    // Flag write and BranchZ in the same cycle
    cyc(0, 0, 0, 0, 1, 0, 3, 1, 1);
`ifdef FLAG_BYPASS_EN
    check("bypass_branch_pc", int'(ProgCtr), 40);
`else
    check("nobypass_branch_pc", int'(ProgCtr), 41);
`endif
    check("flag_set", int'(ZeroFlag), 1);

    // Jump to top of memory then wrap
    cyc(0, 0, 0, 1, 0, 0, 31, 0, 0);
    check("jump_top_pc", int'(ProgCtr), 1023);
    plain();
    check("wrap_pc", int'(ProgCtr), 0);

    // Halt beats Jump
    for (int i = 0; i < 12; i++) plain();
    cyc(0, 0, 1, 1, 0, 0, 3, 0, 0);
    check("halt_pc", int'(ProgCtr), 12);
    check("halt_done", int'(Done), 1);
    check("halt_running", int'(Running), 0);
    plain();
    check("halted_hold_pc", int'(ProgCtr), 12);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("restart_pc", int'(ProgCtr), 0);
    check("restart_done", int'(Done), 0);
    check("restart_flag_kept", int'(ZeroFlag), 1);

    // Async reset in RUN at PC=17
    for (int i = 0; i < 17; i++) plain();
    check("pc_before_reset", int'(ProgCtr), 17);
    async_reset(1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset(0);
      end else begin
        cyc($urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 47) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0,
            int'($urandom_range(0, 31)),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1);
      end
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
